// File: rtl/clock_divider_prog.sv
// Programmable clock-enable generator: registered divided clock plus a one-cycle
// tick per output period, runtime-loadable ratio and a single-step mode.
module clock_divider_prog #(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             step,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             load_pending
);

    localparam logic [CNT_W-1:0] DEF_N  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_CNT = CNT_W'(DEF_DIV - 1);
    localparam logic [CNT_W-1:0] MIN_N  = CNT_W'(2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_act_q, n_act_d;
    logic [CNT_W-1:0] n_pend_q, n_pend_d;
    logic             pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic             at_last, start, adv, apply;
    logic [CNT_W-1:0] cnt_nxt, n_eff;

    always_comb begin
        at_last = (cnt_q == n_act_q - 1'b1);
        start   = en & mode & ~busy_q & step & at_last;
        // In step mode an unfinished period keeps running until the idle position.
        adv     = en & (~mode | busy_q | start | ~at_last);
        apply   = adv & at_last & pend_q;
        n_eff   = apply ? n_pend_q : n_act_q;
        cnt_nxt = at_last ? '0 : cnt_q + 1'b1;

        cnt_d     = cnt_q;
        n_act_d   = n_act_q;
        n_pend_d  = n_pend_q;
        pend_d    = pend_q;
        busy_d    = busy_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;

        if (adv) begin
            cnt_d     = cnt_nxt;
            n_act_d   = n_eff;
            clk_out_d = (cnt_nxt < (n_eff >> 1));
            tick_d    = (cnt_nxt == '0);
        end

        if (!mode) begin
            busy_d = 1'b0;
        end else if (adv) begin
            if (start) busy_d = 1'b1;
            if (cnt_nxt == n_eff - 1'b1) busy_d = 1'b0;
        end

        // A load on the apply edge wins: the old pending value applies, the new one waits.
        if (div_load) begin
            pend_d   = 1'b1;
            n_pend_d = (div_val < MIN_N) ? MIN_N : div_val;
        end else if (apply) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= DEF_CNT;
            n_act_q   <= DEF_N;
            n_pend_q  <= '0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            n_act_q   <= n_act_d;
            n_pend_q  <= n_pend_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out      = clk_out_q;
    assign tick         = tick_q;
    assign busy         = busy_q;
    assign load_pending = pend_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: free-run, ratio loads, single-step,
// enable freeze and asynchronous reset, with hand-computed per-cycle outputs.
module tb_clock_divider_prog;

    logic        clk = 1'b0;
    logic        rst_n, en, mode, step, div_load;
    logic [15:0] div_val;
    logic        clk_out, tick, busy, load_pending;

    int checks = 0;
    int errors = 0;

    clock_divider_prog #(.CNT_W(16), .DEF_DIV(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .step         (step),
        .div_val      (div_val),
        .div_load     (div_load),
        .clk_out      (clk_out),
        .tick         (tick),
        .busy         (busy),
        .load_pending (load_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int idx, input string sig,
                       input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] %s got %b expected %b", tag, idx, sig, obs, exp);
        end
    endtask

    // Vectors read left to right: the leftmost bit is the first edge of the run.
    task automatic run(input string tag, input int n, input logic ld, input logic [15:0] val,
                       input logic [31:0] stepv, input logic [31:0] clkv,
                       input logic [31:0] tickv, input logic [31:0] busyv,
                       input logic [31:0] pendv);
        div_load = ld;
        div_val  = val;
        for (int i = 0; i < n; i++) begin
            step = stepv[n-1-i];
            @(posedge clk);
            #1;
            div_load = 1'b0;
            step     = 1'b0;
            chk(tag, i, "clk_out", clk_out, clkv[n-1-i]);
            chk(tag, i, "tick", tick, tickv[n-1-i]);
            chk(tag, i, "busy", busy, busyv[n-1-i]);
            chk(tag, i, "load_pending", load_pending, pendv[n-1-i]);
        end
    endtask

    task automatic all_zero(input string tag);
        chk(tag, 0, "clk_out", clk_out, 1'b0);
        chk(tag, 0, "tick", tick, 1'b0);
        chk(tag, 0, "busy", busy, 1'b0);
        chk(tag, 0, "load_pending", load_pending, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; step = 1'b0;
        div_load = 1'b0; div_val = '0;
        repeat (2) @(posedge clk);
        #1;
        all_zero("reset");
        #2;
        rst_n = 1'b1;
        en    = 1'b1;

        run("freerun4", 8, 1'b0, 16'd0, 0, 8'b11001100, 8'b10001000, 0, 0);
        run("odd5", 10, 1'b1, 16'd5, 0, 10'b1100110001, 10'b1000100001, 0, 10'b1111000000);
        run("ovr_ld6", 1, 1'b1, 16'd6, 0, 1'b1, 1'b0, 0, 1'b1);
        run("ovr_ld3", 7, 1'b1, 16'd3, 0, 7'b0001001, 7'b0001001, 0, 7'b1110000);
        run("clamp0", 6, 1'b1, 16'd0, 0, 6'b001010, 6'b001010, 0, 6'b110000);
        run("back4", 6, 1'b1, 16'd4, 0, 6'b101100, 6'b101000, 0, 6'b110000);

        mode = 1'b1;
        run("step_idle", 2, 1'b0, 16'd0, 0, 0, 0, 0, 0);
        run("step4", 6, 1'b0, 16'd0, 6'b110000, 6'b110000, 6'b100000, 6'b111000, 0);

        mode = 1'b0;
        run("en_pre", 2, 1'b0, 16'd0, 0, 2'b11, 2'b10, 0, 0);
        en = 1'b0;
        run("en_off", 3, 1'b0, 16'd0, 0, 3'b111, 3'b000, 0, 0);
        en = 1'b1;
        run("en_on", 3, 1'b0, 16'd0, 0, 3'b001, 3'b001, 0, 0);

        mode = 1'b1;
        run("run_to_idle", 4, 1'b0, 16'd0, 0, 4'b1000, 0, 0, 0);
        run("step_rst", 2, 1'b1, 16'd7, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11);

        #2;
        rst_n = 1'b0;
        #1;
        all_zero("async_rst");
        #2;
        rst_n = 1'b1;
        mode  = 1'b0;
        run("post_rst4", 8, 1'b0, 16'd0, 0, 8'b11001100, 8'b10001000, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
